// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_CAM = 1'b1
    } arb_state_t;

    localparam int DEF_MAX_WAIT = 8;
    localparam int DEF_BURST    = 4;

    // A count range of 0..n-1 still needs one bit when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with priority clear and a terminal-count flag.
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (inc && (r_cnt != MAX_V))
            r_cnt <= r_cnt + 1'b1;
    end

    assign at_max = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and the camera
// writer, with bounded camera starvation and bounded forced camera bursts.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int BURST    = DEF_BURST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        cam_req,
    input  logic [31:0] cam_addr,
    input  logic [31:0] cam_wdata,
    output logic        cam_ack,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        forced
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic w_cpu_gnt;
    logic w_cam_gnt;
    logic w_wait_max;
    logic w_burst_max;

    // Grant: CPU first unless the camera currently owns the port; the owner's
    // idle slot always goes to the other requester.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_cam_gnt = 1'b0;
        if (r_state == OWN_CAM) begin
            w_cam_gnt = cam_req;
            w_cpu_gnt = !cam_req && cpu_req;
        end else begin
            w_cpu_gnt = cpu_req;
            w_cam_gnt = !cpu_req && cam_req;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OWN_CPU: if (cam_req && !w_cam_gnt && w_wait_max) w_state_nxt = OWN_CAM;
            OWN_CAM: if (!cam_req || w_burst_max)             w_state_nxt = OWN_CPU;
            default: w_state_nxt = OWN_CPU;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= OWN_CPU;
        else
            r_state <= w_state_nxt;
    end

    sat_counter #(
        .WIDTH ($clog2(MAX_WAIT)),
        .MAX   (MAX_WAIT - 1)
    ) u_wait_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .inc    ((r_state == OWN_CPU) && cam_req && !w_cam_gnt),
        .clr    ((r_state == OWN_CAM) || w_cam_gnt || !cam_req),
        .at_max (w_wait_max)
    );

    // Held clear while the CPU owns the port, so every forced period starts at 0.
    sat_counter #(
        .WIDTH (cnt_width(BURST)),
        .MAX   (BURST - 1)
    ) u_burst_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .inc    ((r_state == OWN_CAM) && w_cam_gnt),
        .clr    (r_state == OWN_CPU),
        .at_max (w_burst_max)
    );

    // Handshake outputs are gated by reset so a burst interrupted by reset
    // never reports a word as written.
    assign cam_ack   = reset && w_cam_gnt;
    assign cpu_stall = reset && cpu_req && !w_cpu_gnt;
    assign mem_we    = reset && (w_cam_gnt || (w_cpu_gnt && cpu_we));
    assign mem_addr  = w_cam_gnt ? cam_addr  : cpu_addr;
    assign mem_wdata = w_cam_gnt ? cam_wdata : cpu_wdata;
    assign cpu_rdata = mem_rdata;
    assign forced    = (r_state == OWN_CAM);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_WAIT=8, BURST=4) with a small memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cam_req;
    logic [31:0] cpu_addr, cpu_wdata, cam_addr, cam_wdata;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, cam_ack, mem_we, forced;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    mem_port_arbiter #(.MAX_WAIT(8), .BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cam_req   (cam_req),
        .cam_addr  (cam_addr),
        .cam_wdata (cam_wdata),
        .cam_ack   (cam_ack),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .forced    (forced)
    );

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        cam_req;
        logic [31:0] cam_addr;
        logic        exp_ack;
        logic        exp_stall;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic        exp_forced;
        logic        chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic kreq, input logic [31:0] kaddr);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        cam_req = kreq; cam_addr = kaddr; cam_wdata = kaddr ^ 32'hA5A5_0000;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        vecs[0] = '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 32'h1000,
                    1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'h80, 32'h0, 1'b0, 32'h1000,
                    1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 1'b0, 32'h0};

        // Reset: outputs gated even with both requesters active.
        reset = 1'b0;
        drive(1'b1, 1'b1, 32'h40, 32'h1, 1'b1, 32'h1000);
        #3;
        chk("rst_ack",    {31'd0, cam_ack},   32'd0);
        chk("rst_stall",  {31'd0, cpu_stall}, 32'd0);
        chk("rst_we",     {31'd0, mem_we},    32'd0);
        chk("rst_forced", {31'd0, forced},    32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            step();
            drive(vecs[i].cpu_req, vecs[i].cpu_we, vecs[i].cpu_addr, vecs[i].cpu_wdata,
                  vecs[i].cam_req, vecs[i].cam_addr);
            chk($sformatf("v%0d_ack", i),    {31'd0, cam_ack},   {31'd0, vecs[i].exp_ack});
            chk($sformatf("v%0d_stall", i),  {31'd0, cpu_stall}, {31'd0, vecs[i].exp_stall});
            chk($sformatf("v%0d_we", i),     {31'd0, mem_we},    {31'd0, vecs[i].exp_we});
            chk($sformatf("v%0d_addr", i),   mem_addr,           vecs[i].exp_addr);
            chk($sformatf("v%0d_forced", i), {31'd0, forced},    {31'd0, vecs[i].exp_forced});
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
        end

        // Continuous contention: 8 blocked, 4 forced acks, repeating every 12.
        for (int c = 0; c < 24; c++) begin
            step();
            drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h2000);
            chk($sformatf("cont%0d_ack", c),    {31'd0, cam_ack},   {31'd0, (c % 12) >= 8});
            chk($sformatf("cont%0d_stall", c),  {31'd0, cpu_stall}, {31'd0, (c % 12) >= 8});
            chk($sformatf("cont%0d_forced", c), {31'd0, forced},    {31'd0, (c % 12) >= 8});
            chk($sformatf("cont%0d_addr", c),   mem_addr, ((c % 12) >= 8) ? 32'h2000 : 32'h200);
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Camera drops its request after two forced acks.
        for (int c = 0; c < 10; c++) begin
            step();
            drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h3000);
            chk($sformatf("drop%0d_ack", c), {31'd0, cam_ack}, {31'd0, c >= 8});
        end
        step();
        drive(1'b1, 1'b1, 32'h300, 32'h55, 1'b0, 32'h3000);
        chk("drop_stall",  {31'd0, cpu_stall}, 32'd0);
        chk("drop_ack",    {31'd0, cam_ack},   32'd0);
        chk("drop_we",     {31'd0, mem_we},    32'd1);
        chk("drop_addr",   mem_addr,           32'h300);
        chk("drop_forced", {31'd0, forced},    32'd1);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("drop_forced_after", {31'd0, forced}, 32'd0);

        // Reset asserted during the second word of a forced burst.
        for (int c = 0; c < 10; c++) begin
            step();
            drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h4000);
            chk($sformatf("rb%0d_ack", c), {31'd0, cam_ack}, {31'd0, c >= 8});
        end
        reset = 1'b0;
        #1;
        chk("rb_ack",    {31'd0, cam_ack},   32'd0);
        chk("rb_stall",  {31'd0, cpu_stall}, 32'd0);
        chk("rb_we",     {31'd0, mem_we},    32'd0);
        chk("rb_forced", {31'd0, forced},    32'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("rb_rel_ack", {31'd0, cam_ack}, 32'd0);
        for (int c = 1; c <= 8; c++) begin
            step();
            drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h4000);
            chk($sformatf("rbw%0d_ack", c),    {31'd0, cam_ack}, {31'd0, c == 8});
            chk($sformatf("rbw%0d_forced", c), {31'd0, forced},  {31'd0, c == 8});
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Camera drops exactly when the wait counter has reached its limit.
        for (int c = 0; c < 7; c++) begin
            step();
            drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h5000);
        end
        step();
        drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h5000);
        chk("sim_ack", {31'd0, cam_ack}, 32'd0);
        for (int c = 0; c < 9; c++) begin
            step();
            drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h5000);
            chk($sformatf("sim%0d_forced", c), {31'd0, forced},  {31'd0, c == 8});
            chk($sformatf("sim%0d_ack", c),    {31'd0, cam_ack}, {31'd0, c == 8});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares the single data-memory port between the pipeline's MEM stage and the camera frame writer. The CPU has priority. A wait counter bounds camera starvation, and a burst counter bounds how long the camera can hold the port. It sits between the execute/memory pipeline register outputs, the camera capture logic and the data memory. While the camera owns the port it raises `cpu_stall` to the hazard logic.

## Interface
- `MAX_WAIT`, 8 — consecutive blocked camera cycles before ownership is forced to the camera (≥2)
- `BURST`, 4 — maximum camera words per forced ownership period (≥1)
- `clk` in 1 — system clock, rising edge
- `reset` in 1 — asynchronous, active-low reset
- `cpu_req` in 1 — MEM stage wants a memory access this cycle
- `cpu_we` in 1 — CPU access is a write
- `cpu_addr` in 32 — CPU address
- `cpu_wdata` in 32 — CPU write data
- `cpu_rdata` out 32 — read data to the MEM stage; equals `mem_rdata`
- `cpu_stall` out 1 — CPU request not served this cycle; freezes the pipeline
- `cam_req` in 1 — camera has a pixel word to write; held until acked
- `cam_addr` in 32 — camera write address
- `cam_wdata` in 32 — camera write data
- `cam_ack` out 1 — camera word written at this clock edge; camera advances
- `mem_we` out 1 — data memory write enable
- `mem_addr` out 32 — data memory address
- `mem_wdata` out 32 — data memory write data
- `mem_rdata` in 32 — data memory combinational read data
- `forced` out 1 — registered; high while in `OWN_CAM`

## Operation
- State machine with two states: `OWN_CPU` and `OWN_CAM`.
- Grant is combinational per cycle. The selected requester drives `mem_we`/`mem_addr`/`mem_wdata`.
- Grant in `OWN_CPU`:
  - `cpu_req`=1: CPU granted. `cam_ack`=0 and `cpu_stall`=0.
  - `cpu_req`=0 and `cam_req`=1: camera granted in the idle slot. `cam_ack`=1.
- Grant in `OWN_CAM`:
  - `cam_req`=1: camera granted. `cam_ack`=1 and `cpu_stall`=`cpu_req`.
  - `cam_req`=0: CPU granted if it requests. No slot is wasted.
- No grant: `mem_we`=0 and `mem_addr`/`mem_wdata` = CPU values.
- The camera is write-only. `cam_ack` implies `mem_we`=1.
- `wait_cnt` (clog2(MAX_WAIT) bits, saturating):
  - increments each cycle in `OWN_CPU` with `cam_req`=1 and `cam_ack`=0;
  - clears on `cam_ack`, on `cam_req`=0, or on entering `OWN_CPU`.
- `OWN_CPU`→`OWN_CAM` at the edge where `wait_cnt`==MAX_WAIT-1 and the camera is still blocked.
- `burst_cnt` clears on entry to `OWN_CAM` and increments per `cam_ack` in `OWN_CAM`.
- `OWN_CAM`→`OWN_CPU` at the edge where either:
  - `cam_ack` occurs with `burst_cnt`==BURST-1, or
  - `cam_req`=0.
- Simultaneous `cam_req` drop and wait expiry: stay in `OWN_CPU`.
- Reset (asynchronous, `reset`=0):
  - state `OWN_CPU`, both counters 0, `forced`=0;
  - while `reset`=0, `cam_ack`, `cpu_stall` and `mem_we` are forced to 0.
- Reset mid-burst: ownership returns to the CPU immediately. No partial word is reported as acked.

## Timing
- Zero-latency grant. Memory outputs are combinational from inputs and state, so an uncontended CPU access completes in its own cycle with no stall.
- Camera worst case under continuous `cpu_req`:
  - blocked for MAX_WAIT cycles, acked in cycle MAX_WAIT;
  - receives BURST consecutive acks, during which `cpu_stall`=1.
- Camera throughput floor under continuous contention: BURST words per MAX_WAIT+BURST cycles.
- `forced` changes only on clock edges.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic {OWN_CPU, OWN_CAM} arb_state_t`;
  - default MAX_WAIT/BURST localparams.
- Sub-module `sat_counter` (WIDTH, MAX; `inc`, `clr`, `at_max`, async active-low reset). Instantiated twice, for `wait_cnt` and `burst_cnt`.

## Test plan
- After reset, `cpu_req`=1 write addr 0x40 data 0xDEADBEEF, `cam_req`=0: `mem_we`=1, `mem_addr`=0x40, `cpu_stall`=0 the same cycle; a read of 0x40 next cycle returns 0xDEADBEEF on `cpu_rdata`.
- `cpu_req`=0 and `cam_req`=1 with addr 0x1000: `cam_ack`=1 that cycle, `mem_addr`=0x1000; `forced` stays 0.
- `cpu_req` held 1 with `cam_req` held 1 (MAX_WAIT=8, BURST=4):
  - `cam_ack`=0 for cycles 0–7;
  - `cam_ack`=1 and `cpu_stall`=1 for cycles 8–11;
  - cycle 12 CPU served with `cpu_stall`=0; the pattern repeats every 12 cycles.
- In `OWN_CAM`, drop `cam_req` after 2 acks with `cpu_req`=1: CPU served that cycle with `cpu_stall`=0, and `forced`=0 after the next edge.
- Assert `reset`=0 during the 2nd word of a forced burst: `cam_ack`, `cpu_stall`, `mem_we` go to 0 immediately; after release the state is `OWN_CPU` with `wait_cnt`=0.
- `cam_req` deasserted at the same edge where `wait_cnt` reaches 7: state stays `OWN_CPU` and `wait_cnt` clears to 0.
